// File: rtl/fetch_unit.sv
// fetch_unit
// Instruction fetch stage. Presents the current PC to instruction memory,
// advances the PC by 4 on each completed fetch, applies branch/exception
// redirects, and queues fetched {pc, instr} pairs in a small circular FIFO
// that feeds decode over a valid/ready handshake.
//
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   pc_in                    current PC from the program counter register
//   pc_write, next_pc        PC register update (combinational)
//   imem_req, imem_addr      instruction memory request / address (= pc_in)
//   imem_ready, imem_rdata   memory completion and returned instruction
//   redirect, redirect_pc    single-cycle redirect pulse and its target
//   if_valid, if_ready       decode handshake
//   if_instr, if_pc          buffer head entry
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no request; waits for a free buffer slot
// FETCH | request outstanding at pc_in; completes on imem_ready
// KILL  | request outstanding but squashed by a redirect; its data is
//       | dropped and the PC jumps to pend_target once it completes
module fetch_unit #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_in,
  output logic        pc_write,
  output logic [31:0] next_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_KILL  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [31:0]       pend_q, pend_d;
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  count_nxt;
  logic [31:0]       buf_pc_q    [DEPTH];
  logic [31:0]       buf_instr_q [DEPTH];

  logic push;
  logic pop;
  logic flush;
  logic space;

  assign imem_req  = (state_q != S_IDLE);
  assign imem_addr = pc_in;

  assign if_valid = (count_q != '0);
  assign if_pc    = buf_pc_q[head_q];
  assign if_instr = buf_instr_q[head_q];

  assign pop   = if_valid & if_ready;
  assign push  = (state_q == S_FETCH) & imem_ready & ~redirect;
  assign flush = redirect;

  // Occupancy after this cycle's push and pop; decides whether another
  // request may be issued next cycle.
  assign count_nxt = count_q + CNT_W'(push) - CNT_W'(pop);
  assign space     = (count_nxt < CNT_W'(DEPTH));

  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    pc_write = 1'b0;
    next_pc  = '0;
    case (state_q)
      S_IDLE: begin
        if (redirect) begin
          pc_write = 1'b1;
          next_pc  = redirect_pc;
        end else if (space) begin
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (imem_ready) begin
          pc_write = 1'b1;
          if (redirect) begin
            next_pc = redirect_pc;
            state_d = S_FETCH;
          end else begin
            next_pc = pc_in + 32'd4;
            state_d = space ? S_FETCH : S_IDLE;
          end
        end else if (redirect) begin
          pend_d  = redirect_pc;
          state_d = S_KILL;
        end
      end
      S_KILL: begin
        // The address must stay put until memory completes, so the jump is
        // deferred to the completing cycle; a redirect in that very cycle
        // still takes priority over the stored target.
        if (imem_ready) begin
          pc_write = 1'b1;
          next_pc  = redirect ? redirect_pc : pend_q;
          state_d  = S_FETCH;
        end else if (redirect) begin
          pend_d = redirect_pc;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // PC update outputs are quiet while reset is held, even if a redirect
    // happens to be asserted.
    if (!rst_n) begin
      pc_write = 1'b0;
      next_pc  = '0;
    end
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_nxt;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) tail_d = tail_q + PTR_W'(1);
      if (pop)  head_d = head_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pend_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Buffer payload needs no reset; entries are only read while counted valid.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_pc_q[tail_q]    <= pc_in;
      buf_instr_q[tail_q] <= imem_rdata;
    end
  end

endmodule
